// File: rtl/fsm_seq_monitor_if.sv
// fsm_seq_monitor_if: sequencer sample/control inputs and monitor status outputs.
interface fsm_seq_monitor_if;
   logic [2:0] state_in;
   logic       enable;
   logic       clear_err;
   logic       fault;
   logic [1:0] err_code;
   logic [7:0] wrap_count;
   logic [1:0] mon_state;
   modport master (output state_in, enable, clear_err, input fault, err_code, wrap_count, mon_state);
   modport slave  (input state_in, enable, clear_err, output fault, err_code, wrap_count, mon_state);
endinterface

// File: rtl/fsm_seq_monitor.sv
// fsm_seq_monitor: checks a 4-state sequencer for legal steps, range and stuck states,
// latches the first error code and counts completed laps.
module fsm_seq_monitor #(
   parameter int STUCK_MAX = 8,
   parameter int CNT_W     = 4
) (
   input logic clk,
   input logic rst_n,
   fsm_seq_monitor_if.slave mon
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SYNC  = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;
   logic [1:0]       r_state;
   logic [1:0]       r_prev;
   logic [CNT_W-1:0] r_hold;
   logic             r_fault;
   logic [1:0]       r_code;
   logic [7:0]       r_wrap;
   logic             w_oor;
   logic             w_eq;
   logic             w_nx;
   logic             w_stuck;
   logic             w_clr;
   logic [1:0]       w_succ;
   logic [1:0]       w_err;
   logic [1:0]       w_nstate;
   always_comb begin
      w_succ   = r_prev + 2'd1;
      w_oor    = mon.state_in[2];
      w_eq     = !w_oor && mon.state_in[1:0] == r_prev;
      w_nx     = !w_oor && mon.state_in[1:0] == w_succ;
      // hold_cnt counts repeats after the accepted sample, so the trip point is one short
      w_stuck  = w_eq && r_hold == CNT_W'(STUCK_MAX - 2);
      w_clr    = mon.clear_err && (r_state == S_IDLE || r_state == S_FAULT);
      w_err    = r_state == S_SYNC ? (w_oor ? 2'b10 : 2'b00) :
                 r_state != S_RUN  ? 2'b00 :
                 w_oor             ? 2'b10 :
                 !w_eq && !w_nx    ? 2'b01 :
                 w_stuck           ? 2'b11 : 2'b00;
      w_nstate = !mon.enable          ? S_IDLE :
                 r_state == S_IDLE    ? S_SYNC :
                 r_state == S_FAULT   ? (mon.clear_err ? S_SYNC : S_FAULT) :
                 w_err != 2'b00       ? S_FAULT :
                 S_RUN;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_prev  <= 2'd0;
         r_hold  <= '0;
         r_fault <= 1'b0;
         r_code  <= 2'b00;
         r_wrap  <= 8'd0;
      end else begin
         r_state <= w_nstate;
         if (w_clr) begin
            r_fault <= 1'b0;
            r_code  <= 2'b00;
         end else if (mon.enable && w_err != 2'b00) begin
            r_fault <= 1'b1;
            if (!r_fault) r_code <= w_err;
         end
         if (mon.enable && r_state == S_SYNC && !w_oor) begin
            r_prev <= mon.state_in[1:0];
            r_hold <= '0;
         end
         if (mon.enable && r_state == S_RUN && w_err == 2'b00) begin
            if (w_eq) r_hold <= r_hold + 1'b1;
            else begin
               r_prev <= mon.state_in[1:0];
               r_hold <= '0;
               if (r_prev == 2'd3 && r_wrap != 8'hFF) r_wrap <= r_wrap + 8'd1;
            end
         end
      end
   end
   assign mon.fault      = r_fault;
   assign mon.err_code   = r_code;
   assign mon.wrap_count = r_wrap;
   assign mon.mon_state  = r_state;
endmodule

// File: tb/tb_fsm_seq_monitor.sv
// tb_fsm_seq_monitor: directed vector table, corner sequences and randomized run
// checked against a run-length/lap-counting reference model.
module tb_fsm_seq_monitor;
   localparam int STUCK = 8;
   typedef struct {
      logic       en;
      logic       clr;
      logic [2:0] s;
      logic       f;
      logic [1:0] c;
      logic [1:0] st;
      logic [7:0] w;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int tests = 0;
   int fails = 0;
   vec_t tbl[$];
   int m_mode, m_last, m_run, m_fault, m_code, m_laps;
   fsm_seq_monitor_if bus();
   fsm_seq_monitor #(.STUCK_MAX(STUCK), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .mon(bus.slave));
   always #5 clk = ~clk;
   task automatic add(input logic en, clr, input logic [2:0] s, input logic f,
                      input logic [1:0] c, st, input logic [7:0] w);
      tbl.push_back('{en, clr, s, f, c, st, w});
   endtask
   task automatic chk(input string name, input logic f, input logic [1:0] c, st, input logic [7:0] w);
      tests++;
      if (bus.fault !== f || bus.err_code !== c || bus.mon_state !== st || bus.wrap_count !== w) begin
         fails++;
         $display("FAIL %s: got fault=%0b code=%0d state=%0d wrap=%0d, expected fault=%0b code=%0d state=%0d wrap=%0d",
                  name, bus.fault, bus.err_code, bus.mon_state, bus.wrap_count, f, c, st, w);
      end
   endtask
   task automatic m_reset();
      m_mode = 0; m_last = 0; m_run = 0; m_fault = 0; m_code = 0; m_laps = 0;
   endtask
   task automatic m_flag(input int code);
      m_fault = 1;
      if (m_code == 0) m_code = code;
      m_mode = 3;
   endtask
   task automatic m_step();
      int s;
      s = int'(bus.state_in);
      if (bus.clear_err && (m_mode == 0 || m_mode == 3)) begin
         m_fault = 0; m_code = 0;
      end
      if (!bus.enable) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
         if (s > 3) m_flag(2);
         else begin m_last = s; m_run = 1; m_mode = 2; end
      end else if (m_mode == 2) begin
         if (s > 3) m_flag(2);
         else if (s == m_last) begin
            if (m_run + 1 >= STUCK) m_flag(3);
            else m_run++;
         end else if (s == (m_last + 1) % 4) begin
            if (m_last == 3 && m_laps < 255) m_laps++;
            m_last = s; m_run = 1;
         end else m_flag(1);
      end else if (bus.clear_err) m_mode = 1;
   endtask
   task automatic drive(input logic en, clr, input logic [2:0] s);
      bus.enable = en; bus.clear_err = clr; bus.state_in = s;
   endtask
   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
   endtask
   task automatic mchk(input string name);
      chk(name, m_fault != 0, 2'(m_code), 2'(m_mode), 8'(m_laps));
   endtask
   initial begin
      int hold_pct, r;
      logic [2:0] s;
      add(1,0,0, 0,0,1,0);
      add(1,0,0, 0,0,2,0);
      add(1,0,1, 0,0,2,0); add(1,0,2, 0,0,2,0); add(1,0,3, 0,0,2,0); add(1,0,0, 0,0,2,1);
      add(1,0,1, 0,0,2,1); add(1,0,2, 0,0,2,1); add(1,0,3, 0,0,2,1); add(1,0,0, 0,0,2,2);
      add(1,0,1, 0,0,2,2);
      add(1,0,3, 1,1,3,2);
      add(1,0,5, 1,1,3,2);
      add(1,1,0, 0,0,1,2);
      add(1,0,6, 1,2,3,2);
      add(1,1,0, 0,0,1,2);
      add(1,0,2, 0,0,2,2);
      for (int i = 0; i < 6; i++) add(1,0,2, 0,0,2,2);
      add(1,0,2, 1,3,3,2);
      add(0,1,2, 0,0,0,2);
      add(1,0,0, 0,0,1,2);
      drive(0, 0, 0);
      m_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset", 0, 0, 0, 0);
      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].clr, tbl[i].s);
         tick();
         chk($sformatf("vec%0d", i), tbl[i].f, tbl[i].c, tbl[i].st, tbl[i].w);
      end
      for (int i = 0; i < 7; i++) begin
         drive(1, 0, 2);
         tick();
         chk("near_stuck_hold", 0, 0, 2, 2);
      end
      drive(1, 0, 3);
      tick();
      chk("near_stuck_step", 0, 0, 2, 2);
      drive(1, 0, 7);
      tick();
      chk("oor_run", 1, 2, 3, 2);
      #2 rst_n = 1'b0;
      m_reset();
      #1 chk("async_reset", 0, 0, 0, 0);
      @(posedge clk);
      #1 chk("reset_held", 0, 0, 0, 0);
      rst_n = 1'b1;
      drive(1, 0, 0);
      tick();
      tick();
      for (int l = 0; l < 260; l++)
         for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 3'(k % 4));
            tick();
            if (k == 4 && (l % 32 == 0)) mchk("lap_model");
         end
      chk("wrap_saturate", 0, 0, 2, 8'd255);
      hold_pct = 40;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) hold_pct = ($urandom_range(0, 1) != 0) ? 90 : 40;
         r = int'($urandom_range(0, 99));
         s = r < hold_pct ? 3'(m_last) :
             r < 92       ? 3'((m_last + 1) % 4) :
             r < 96       ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
         drive($urandom_range(0, 59) != 0, $urandom_range(0, 14) == 0, s);
         tick();
         mchk("random");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
